// File: rtl/serial_tx_queue.sv
// serial_tx_queue: valid/ready FIFO feeding a framed serializer over LINES lines.
// Frame: one all-ones start beat, LENGTH/LINES data beats MSB-first, optional even parity, GAP zero beats.
module serial_tx_queue #(
   parameter int LENGTH = 32,
   parameter int LINES  = 1,
   parameter int DEPTH  = 4,
   parameter int PARITY = 1,
   parameter int GAP    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid,
   output logic                       ready,
   input  logic [LENGTH-1:0]          data_in,
   output logic [LINES-1:0]           d,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int BEATS = LENGTH / LINES;
   localparam int CW    = $clog2(((BEATS > GAP) ? BEATS : GAP) + 1);
   localparam int PW    = $clog2(DEPTH);
   localparam int LW    = $clog2(DEPTH + 1);

   localparam logic [CW-1:0] C_BEAT_LAST = CW'(BEATS - 1);
   localparam logic [CW-1:0] C_GAP_LAST  = CW'(GAP - 1);
   localparam logic [LW-1:0] C_DEPTH     = LW'(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   // Line j of a beat carries the j-th bit below the current MSB of the shift register.
   function automatic logic [LINES-1:0] f_group(input logic [LENGTH-1:0] w);
      logic [LINES-1:0] g;
      for (int j = 0; j < LINES; j++) begin
         g[j] = w[LENGTH-1-j];
      end
      return g;
   endfunction

   function automatic logic [LINES-1:0] f_parity(input logic [LENGTH-1:0] w);
      logic [LINES-1:0] p;
      p = {LINES{1'b0}};
      for (int k = 0; k < BEATS; k++) begin
         for (int j = 0; j < LINES; j++) begin
            p[j] = p[j] ^ w[LENGTH-1-(k*LINES+j)];
         end
      end
      return p;
   endfunction

   logic [LENGTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              r_rdy_en;
   logic [2:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic [LENGTH-1:0] r_shreg;
   logic [LINES-1:0]  r_par;
   logic [LINES-1:0]  r_d;
   logic              w_push;
   logic              w_pop;
   logic [LENGTH-1:0] w_head;

   assign ready  = r_rdy_en && (r_level < C_DEPTH);
   assign w_head = r_mem[r_rd_ptr];
   assign d      = r_d;
   assign busy   = (r_state != S_IDLE);
   assign level  = r_level;

   // Handshake and pop decision; a pop happens from IDLE or on the last gap beat.
   always_comb begin
      w_push = valid && ready;
      w_pop  = 1'b0;
      if (r_level != {LW{1'b0}}) begin
         if (r_state == S_IDLE) begin
            w_pop = 1'b1;
         end else if ((r_state == S_GAP) && (r_cnt == C_GAP_LAST)) begin
            w_pop = 1'b1;
         end else begin
            w_pop = 1'b0;
         end
      end else begin
         w_pop = 1'b0;
      end
   end

   // FIFO storage; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   // FIFO pointers, occupancy and the post-reset ready enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= {PW{1'b0}};
         r_rd_ptr <= {PW{1'b0}};
         r_level  <= {LW{1'b0}};
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Frame sequencer: d is registered and always shows the beat of the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= {CW{1'b0}};
         r_shreg <= {LENGTH{1'b0}};
         r_par   <= {LINES{1'b0}};
         r_d     <= {LINES{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_START;
                  r_shreg <= w_head;
                  r_par   <= f_parity(w_head);
                  r_d     <= {LINES{1'b1}};
               end else begin
                  r_d     <= {LINES{1'b0}};
               end
            end
            S_START: begin
               r_state <= S_DATA;
               r_cnt   <= {CW{1'b0}};
               r_d     <= f_group(r_shreg);
               r_shreg <= r_shreg << LINES;
            end
            S_DATA: begin
               if (r_cnt == C_BEAT_LAST) begin
                  r_cnt <= {CW{1'b0}};
                  if (PARITY != 0) begin
                     r_state <= S_PAR;
                     r_d     <= r_par;
                  end else begin
                     r_state <= S_GAP;
                     r_d     <= {LINES{1'b0}};
                  end
               end else begin
                  r_cnt   <= r_cnt + CW'(1);
                  r_d     <= f_group(r_shreg);
                  r_shreg <= r_shreg << LINES;
               end
            end
            S_PAR: begin
               r_state <= S_GAP;
               r_cnt   <= {CW{1'b0}};
               r_d     <= {LINES{1'b0}};
            end
            S_GAP: begin
               if (r_cnt == C_GAP_LAST) begin
                  r_cnt <= {CW{1'b0}};
                  if (w_pop) begin
                     r_state <= S_START;
                     r_shreg <= w_head;
                     r_par   <= f_parity(w_head);
                     r_d     <= {LINES{1'b1}};
                  end else begin
                     r_state <= S_IDLE;
                     r_d     <= {LINES{1'b0}};
                  end
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  r_d   <= {LINES{1'b0}};
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= {CW{1'b0}};
               r_d     <= {LINES{1'b0}};
            end
         endcase
      end
   end

endmodule
